// File: rtl/misr_compactor_if.sv
// ============================================================================
// Module  : misr_compactor_if
// Brief   : Session-control and response bus between a BIST sequencer and the MISR compactor.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface misr_compactor_if #(
    parameter int WIDTH  = 16,
    parameter int INPUTS = 1,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  len;
    logic              si_valid;
    logic [INPUTS-1:0] si;
    logic [WIDTH-1:0]  golden;
    logic [WIDTH-1:0]  misr;
    logic              sign;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  remaining;

    modport master (
        output start, abort, len, si_valid, si, golden,
        input  misr, sign, busy, done, pass, remaining
    );

    modport slave (
        input  start, abort, len, si_valid, si, golden,
        output misr, sign, busy, done, pass, remaining
    );
endinterface

`default_nettype wire

// File: rtl/misr_compactor.sv
// ============================================================================
// Module  : misr_compactor
// Brief   : Galois MISR with IDLE/RUN/DONE session control and golden-signature compare.
// Revision: 1.0
// ============================================================================
`default_nettype none

module misr_compactor #(
    parameter int               WIDTH   = 16,
    parameter int               INPUTS  = 1,
    parameter int               INJ_LSB = 11,
    parameter logic [WIDTH-1:0] POLY    = 16'h002D,
    parameter logic [WIDTH-1:0] SEED    = 16'hFFFF,
    parameter int               CNT_W   = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    misr_compactor_if.slave     bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_misr;
    logic [CNT_W-1:0] r_remaining;
    logic             r_pass;

    logic [WIDTH-1:0] w_inj;
    logic [WIDTH-1:0] w_next;
    logic             w_load;

    always_comb begin
        w_inj = '0;
        for (int i = 0; i < INPUTS; i++) begin
            w_inj[INJ_LSB+i] = bus.si[i];
        end
        w_next = {r_misr[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{r_misr[WIDTH-1]}}) ^ w_inj;
    end

    // A new session may begin from IDLE or DONE; abort always wins over start.
    assign w_load = bus.start && !bus.abort && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_misr      <= SEED;
            r_remaining <= '0;
            r_pass      <= 1'b0;
        end else if (bus.abort && (r_state == S_RUN || r_state == S_DONE)) begin
            r_state <= S_IDLE;
            r_pass  <= 1'b0;
        end else if (w_load) begin
            r_misr      <= SEED;
            r_remaining <= bus.len;
            if (bus.len != '0) begin
                r_state <= S_RUN;
                r_pass  <= 1'b0;
            end else begin
                r_state <= S_DONE;
                r_pass  <= (SEED == bus.golden);
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.si_valid) begin
                        r_misr      <= w_next;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= S_DONE;
                            r_pass  <= (w_next == bus.golden);
                        end
                    end
                end
                S_IDLE, S_DONE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.misr      = r_misr;
    assign bus.sign      = r_misr[WIDTH-1];
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.pass      = r_pass;
    assign bus.remaining = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_misr_compactor.sv
// ============================================================================
// Module  : tb_misr_compactor
// Brief   : Scoreboarded random and directed bench for misr_compactor against a polynomial model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_misr_compactor;

    localparam logic [15:0] C_SEED = 16'hFFFF;
    localparam logic [15:0] C_POLY = 16'h002D;
    localparam int          C_INJ  = 11;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];
    logic prev_done;

    misr_compactor_if #(.WIDTH(16), .INPUTS(1), .CNT_W(16)) bus ();

    misr_compactor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signature as polynomial arithmetic: s = s*x mod P(x), plus the sample term x^INJ.
    function automatic logic [15:0] model(input logic [63:0] bits, input int n);
        int unsigned s;
        s = 32'(C_SEED);
        for (int k = 0; k < n; k++) begin
            s = s << 1;
            if ((s & 32'h0001_0000) != 0) s = s ^ (32'h0001_0000 | 32'(C_POLY));
            if (bits[k]) s = s ^ (32'd1 << C_INJ);
        end
        return s[15:0];
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (bus.done && !prev_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_misr", 32'(bus.misr), 32'(e.sig));
                chk("sb_pass", 32'(bus.pass), 32'(e.pass));
            end
        end
        prev_done = bus.done;
    end

    task automatic session(input int n, input logic [63:0] bits, input logic [15:0] gold,
                           input int stall_pct);
        logic [15:0] e;
        int k;
        int cyc;
        if (bus.done && n == 0) begin
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
        end
        e = model(bits, n);
        sb_q.push_back('{sig: e, pass: (e == gold)});
        bus.start = 1'b1; bus.len = 16'(n); bus.golden = gold; bus.si_valid = 1'b0;
        tick();
        bus.start = 1'b0;
        k = 0; cyc = 0;
        while (k < n && cyc < 1000) begin
            bus.si_valid = ($urandom_range(99) >= 32'(stall_pct));
            bus.si       = bits[k];
            tick();
            if (bus.si_valid) k++;
            cyc++;
        end
        bus.si_valid = 1'b0;
        chk("session_complete", 32'(k), 32'(n));
        chk("done_after_last", 32'(bus.done), 32'd1);
    endtask

    initial begin
        logic [63:0] bits;
        logic [15:0] g;
        int          n;
        n_checks = 0; n_pass = 0; prev_done = 1'b0;
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.len = 0; bus.si_valid = 0; bus.si = 0; bus.golden = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_misr", 32'(bus.misr), 32'hFFFF);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pass", 32'(bus.pass), 32'd0);
        chk("rst_sign", 32'(bus.sign), 32'd1);
        chk("rst_remaining", 32'(bus.remaining), 32'd0);

        session(1, 64'h0, 16'hFFD3, 0);
        chk("one_zero_misr", 32'(bus.misr), 32'hFFD3);
        session(1, 64'h0, 16'h0000, 0);
        chk("one_zero_fail_pass", 32'(bus.pass), 32'd0);
        session(1, 64'h1, 16'hF7D3, 0);
        chk("inject_bit11", 32'(bus.misr), 32'hF7D3);
        session(2, 64'h0, 16'hFF8B, 0);
        chk("two_zero_misr", 32'(bus.misr), 32'hFF8B);

        // Stall in the middle of a two-sample session.
        sb_q.push_back('{sig: 16'hFF8B, pass: 1'b1});
        bus.start = 1; bus.len = 2; bus.golden = 16'hFF8B; bus.si_valid = 0; bus.si = 0;
        tick();
        bus.start = 0;
        chk("stall_busy0", 32'(bus.busy), 32'd1);
        bus.si_valid = 1; tick();
        chk("stall_misr1", 32'(bus.misr), 32'hFFD3);
        bus.si_valid = 0; tick();
        chk("stall_hold", 32'(bus.misr), 32'hFFD3);
        chk("stall_rem", 32'(bus.remaining), 32'd1);
        chk("stall_busy", 32'(bus.busy), 32'd1);
        bus.si_valid = 1; tick();
        bus.si_valid = 0;
        chk("stall_final", 32'(bus.misr), 32'hFF8B);
        chk("stall_rem0", 32'(bus.remaining), 32'd0);

        session(0, 64'h0, 16'hFFFF, 0);
        chk("len0_busy", 32'(bus.busy), 32'd0);
        chk("len0_misr", 32'(bus.misr), 32'hFFFF);

        // Abort one cycle into a four-sample session.
        bus.abort = 1; tick(); bus.abort = 0;
        bus.start = 1; bus.len = 4; bus.si_valid = 1; bus.si = 0;
        tick();
        bus.start = 0; tick();
        bus.abort = 1; tick(); bus.abort = 0; bus.si_valid = 0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_pass", 32'(bus.pass), 32'd0);
        chk("abort_rem_hold", 32'(bus.remaining), 32'd3);
        chk("abort_misr_hold", 32'(bus.misr), 32'hFFD3);

        // start held through RUN must not reload.
        g = 16'($urandom);
        sb_q.push_back('{sig: model(64'h0, 3), pass: (model(64'h0, 3) == g)});
        bus.start = 1; bus.len = 3; bus.golden = g; tick();
        bus.len = 7; bus.si_valid = 1; tick();
        tick();
        chk("start_held_rem", 32'(bus.remaining), 32'd1);
        bus.start = 0; tick();
        bus.si_valid = 0;
        chk("start_held_done", 32'(bus.done), 32'd1);

        // Restart directly from DONE.
        bus.start = 1; bus.len = 2; tick(); bus.start = 0;
        chk("restart_misr", 32'(bus.misr), 32'hFFFF);
        chk("restart_busy", 32'(bus.busy), 32'd1);
        chk("restart_rem", 32'(bus.remaining), 32'd2);

        // Reset mid-RUN.
        bus.si_valid = 1; tick(); bus.si_valid = 0;
        rst = 1; tick(); rst = 0;
        chk("midrst_misr", 32'(bus.misr), 32'hFFFF);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_rem", 32'(bus.remaining), 32'd0);

        for (int t = 0; t < 24; t++) begin
            bits = {$urandom, $urandom};
            n    = $urandom_range(40);
            g    = ($urandom_range(1) == 1) ? model(bits, n) : 16'($urandom);
            session(n, bits, g, 30);
        end

        tick(); tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
